// File: rtl/eth_tx_fcs_append.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_fcs_append
//  Description : Transmit framing stage in front of an 8-bit parallel CRC-32
//                generator. Passes payload bytes through and pads short
//                frames to a minimum length. Steers the CRC generator through
//                re-init, compute and unload, and appends the four FCS bytes
//                it shifts out. Holds an idle inter-frame gap before the next
//                frame is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_fcs_append #(
    parameter int         MIN_PAYLOAD = 60,     // bytes before FCS, 0 = no padding
    parameter logic [7:0] PAD_BYTE    = 8'h00,  // value of pad bytes
    parameter int         IFG_CYCLES  = 12      // idle cycles after last FCS byte (>=1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       crc_clken,
    output logic       crc_reset,
    output logic       crc_load,
    output logic       crc_compute,
    output logic [7:0] crc_data_in,
    input  logic [7:0] crc_data_out
);

    // ifg_cnt only has to reach IFG_CYCLES-1
    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [15:0]      c_min_len  = 16'(MIN_PAYLOAD);
    localparam logic [16:0]      c_min_ext  = {1'b0, c_min_len};
    localparam logic [IFG_W-1:0] c_ifg_last = IFG_W'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAD  = 3'd2,
        ST_FCS  = 3'd3,
        ST_IFG  = 3'd4
    } state_t;

    state_t           state_q,    state_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic [1:0]       fcs_cnt_q,  fcs_cnt_d;
    logic [IFG_W-1:0] ifg_cnt_q,  ifg_cnt_d;

    // byte_cnt+1 at full width so the compare against MIN_PAYLOAD never wraps
    logic [16:0] w_cnt_plus1;
    // byte_cnt advanced by one, saturating at MIN_PAYLOAD
    logic [15:0] w_cnt_sat;

    assign w_cnt_plus1 = {1'b0, byte_cnt_q} + 17'd1;
    assign w_cnt_sat   = (byte_cnt_q < c_min_len) ? w_cnt_plus1[15:0] : byte_cnt_q;

    // State and counter registers; reset drops straight back to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 16'd0;
            fcs_cnt_q  <= 2'd0;
            ifg_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            fcs_cnt_q  <= fcs_cnt_d;
            ifg_cnt_q  <= ifg_cnt_d;
        end
    end

    // Next-state, counter updates and all handshake/CRC steering outputs
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        fcs_cnt_d   = fcs_cnt_q;
        ifg_cnt_d   = ifg_cnt_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_last    = 1'b0;
        crc_clken   = 1'b0;
        crc_reset   = 1'b0;
        crc_load    = 1'b0;
        crc_compute = 1'b0;
        crc_data_in = 8'h00;

        case (state_q)
            ST_IDLE: begin
                // CRC is re-initialised every idle cycle, including the
                // one-cycle bubble before the first payload byte
                crc_clken  = 1'b1;
                crc_reset  = 1'b1;
                byte_cnt_d = 16'd0;
                fcs_cnt_d  = 2'd0;
                ifg_cnt_d  = '0;
                if (in_valid) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                out_valid = in_valid;
                out_data  = in_data;
                in_ready  = out_ready;
                if (in_valid && out_ready) begin
                    crc_clken   = 1'b1;
                    crc_compute = 1'b1;
                    crc_data_in = in_data;
                    byte_cnt_d  = w_cnt_sat;
                    if (in_last) begin
                        if (w_cnt_plus1 < c_min_ext) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d   = ST_FCS;
                            fcs_cnt_d = 2'd0;
                        end
                    end
                end
            end

            ST_PAD: begin
                out_valid = 1'b1;
                out_data  = PAD_BYTE;
                if (out_ready) begin
                    crc_clken   = 1'b1;
                    crc_compute = 1'b1;
                    crc_data_in = PAD_BYTE;
                    byte_cnt_d  = w_cnt_sat;
                    if (w_cnt_plus1 == c_min_ext) begin
                        state_d   = ST_FCS;
                        fcs_cnt_d = 2'd0;
                    end
                end
            end

            ST_FCS: begin
                // CRC generator presents the next FCS byte, MSB byte first;
                // each accepted byte shifts the next one into place
                out_valid = 1'b1;
                out_data  = crc_data_out;
                out_last  = (fcs_cnt_q == 2'd3);
                if (out_ready) begin
                    crc_clken = 1'b1;
                    crc_load  = 1'b1;
                    fcs_cnt_d = fcs_cnt_q + 2'd1;
                    if (fcs_cnt_q == 2'd3) begin
                        state_d   = ST_IFG;
                        ifg_cnt_d = '0;
                    end
                end
            end

            ST_IFG: begin
                if (ifg_cnt_q == c_ifg_last) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_fcs_append.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_tx_fcs_append
//  Description : Scoreboard bench for eth_tx_fcs_append with a behavioural
//                CRC-32 generator attached to each DUT instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_fcs_append;

    localparam int MIN_P = 60;
    localparam int IFG   = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [7:0] in_data, out_data, crc_data_in, crc_data_out;
    logic       crc_clken, crc_reset, crc_load, crc_compute;

    logic       z_in_valid, z_in_ready, z_in_last, z_out_valid, z_out_ready, z_out_last;
    logic [7:0] z_in_data, z_out_data, z_crc_data_in, z_crc_data_out;
    logic       z_crc_clken, z_crc_reset, z_crc_load, z_crc_compute;

    eth_tx_fcs_append #(.MIN_PAYLOAD(MIN_P), .PAD_BYTE(8'h00), .IFG_CYCLES(IFG)) u_dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .crc_clken(crc_clken), .crc_reset(crc_reset), .crc_load(crc_load),
        .crc_compute(crc_compute), .crc_data_in(crc_data_in), .crc_data_out(crc_data_out)
    );

    eth_tx_fcs_append #(.MIN_PAYLOAD(0), .PAD_BYTE(8'h00), .IFG_CYCLES(1)) u_dut_nopad (
        .clk(clk), .reset(rst),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data), .in_last(z_in_last),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data), .out_last(z_out_last),
        .crc_clken(z_crc_clken), .crc_reset(z_crc_reset), .crc_load(z_crc_load),
        .crc_compute(z_crc_compute), .crc_data_in(z_crc_data_in), .crc_data_out(z_crc_data_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC-32, polynomial 04C11DB7, MSB-first, one byte
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction

    // Behavioural CRC generators: sync re-init, compute, byte unload
    logic [31:0] crc_reg   = 32'hFFFFFFFF;
    logic [31:0] z_crc_reg = 32'hFFFFFFFF;
    always @(posedge clk) begin
        if (crc_clken) begin
            if (crc_reset)        crc_reg <= 32'hFFFFFFFF;
            else if (crc_compute) crc_reg <= crc_byte(crc_reg, crc_data_in);
            else if (crc_load)    crc_reg <= {crc_reg[23:0], 8'h00};
        end
        if (z_crc_clken) begin
            if (z_crc_reset)        z_crc_reg <= 32'hFFFFFFFF;
            else if (z_crc_compute) z_crc_reg <= crc_byte(z_crc_reg, z_crc_data_in);
            else if (z_crc_load)    z_crc_reg <= {z_crc_reg[23:0], 8'h00};
        end
    end
    assign crc_data_out   = ~crc_reg[31:24];
    assign z_crc_data_out = ~z_crc_reg[31:24];

    // ---------------- reference model and scoreboard ----------------
    logic [8:0] exp_q[$];   // {last, data}
    logic [7:0] frame_q[$];

    // Expected wire image: payload, pad to MIN_P, then ~CRC MSB byte first
    task automatic model_push();
        logic [7:0]  f[$];
        logic [31:0] c;
        f = frame_q;
        while (f.size() < MIN_P) f.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (f[i]) c = crc_byte(c, f[i]);
        c = ~c;
        foreach (f[i]) exp_q.push_back({1'b0, f[i]});
        for (int k = 3; k >= 0; k--) exp_q.push_back({(k == 0), c[8*k +: 8]});
    endtask

    logic [31:0] acc = 32'hFFFFFFFF;
    int          frame_hs = 0;
    int          last_frame_len = 0;
    logic        gap_check = 1'b0;
    logic        gap_on = 1'b0;
    int          gap = 0;
    logic [8:0]  mon_e;

    always @(negedge clk) begin
        if (rst) begin
            acc      = 32'hFFFFFFFF;
            frame_hs = 0;
            gap_on   = 1'b0;
        end else begin
            if (gap_on) begin
                if (in_ready) begin
                    chk("ifg_in_ready_low_cycles", gap, IFG + 1);
                    gap_on    = 1'b0;
                    gap_check = 1'b0;
                end else begin
                    gap++;
                    if (gap > 2000) begin
                        chk("ifg_gap_bound", gap, IFG + 1);
                        gap_on    = 1'b0;
                        gap_check = 1'b0;
                    end
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_byte", {23'd0, out_last, out_data}, 32'hFFFFFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e[7:0]);
                    chk("out_last", out_last, mon_e[8]);
                end
                acc = crc_byte(acc, out_data);
                frame_hs++;
                if (out_last) begin
                    chk("fcs_residue", acc, 32'hC704DD7B);
                    acc            = 32'hFFFFFFFF;
                    last_frame_len = frame_hs;
                    frame_hs       = 0;
                    if (gap_check) begin
                        gap_on = 1'b1;
                        gap    = 0;
                    end
                end
            end
        end
    end

    // ---------------- downstream ready generator ----------------
    int   rdy_mode = 0;  // 0 always ready, 1 random, 2 stall on FCS byte 2
    logic stall_done = 1'b0;
    logic [7:0] held;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else if (rdy_mode == 2 && frame_hs == MIN_P + 1 && !stall_done) begin
                stall_done = 1'b1;
                out_ready  = 1'b0;
                held       = out_data;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_out_data", out_data, held);
                    chk("stall_crc_load", crc_load, 1'b0);
                    chk("stall_crc_clken", crc_clken, 1'b0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_frame(input int len);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
    endtask

    // Sends frame_q; abort_at>0 pulses reset after that many bytes
    task automatic send_frame(input bit gaps, input int abort_at, input bit hold);
        int  n;
        bit  ok;
        int  len;
        len = frame_q.size();
        if (abort_at == 0) model_push();
        else for (int i = 0; i < abort_at; i++) exp_q.push_back({1'b0, frame_q[i]});
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == len - 1);
            n  = 0;
            ok = 1'b0;
            while (n < 1000) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
                n++;
            end
            @(posedge clk); #1;
            if (!ok) begin
                chk("in_handshake_timeout", n, 0);
                in_valid = 1'b0;
                return;
            end
            if (abort_at != 0 && i + 1 == abort_at) begin
                in_last = 1'b0;
                rst     = 1'b1;
                #1;
                chk("abort_out_valid", out_valid, 1'b0);
                chk("abort_crc_reset", crc_reset, 1'b1);
                in_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
        end
        if (!hold) in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        chk("first_after_last_valid", out_valid, 1'b1);
        chk("first_after_last_notlast", out_last, 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (IFG + 4) @(posedge clk);
        #1;
    endtask

    // no-pad instance: collect every accepted output byte
    logic [8:0] z_got[$];
    always @(negedge clk) begin
        if (!rst && z_out_valid && z_out_ready) z_got.push_back({z_out_last, z_out_data});
    end

    logic [7:0] z_msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [8:0] z_exp [13];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        z_in_valid = 1'b0; z_in_data = 8'h00; z_in_last = 1'b0; z_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_out_data", out_data, 8'h00);
        chk("reset_crc_clken", crc_clken, 1'b1);
        chk("reset_crc_reset", crc_reset, 1'b1);
        chk("reset_crc_load_compute", {crc_load, crc_compute}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;

        // no-pad instance: ASCII "123456789"
        for (int i = 0; i < 9; i++) z_exp[i] = {1'b0, z_msg[i]};
        z_exp[9]  = {1'b0, 8'hFC};
        z_exp[10] = {1'b0, 8'h89};
        z_exp[11] = {1'b0, 8'h19};
        z_exp[12] = {1'b1, 8'h18};
        for (int i = 0; i < 9; i++) begin
            z_in_valid = 1'b1;
            z_in_data  = z_msg[i];
            z_in_last  = (i == 8);
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                if (z_in_ready) break;
                n++;
            end
            @(posedge clk); #1;
            if (n >= 100) chk("nopad_handshake_timeout", n, 0);
        end
        z_in_valid = 1'b0;
        z_in_last  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("nopad_out_count", z_got.size(), 13);
        for (int i = 0; i < 13; i++) begin
            if (i < z_got.size()) chk("nopad_out_byte", z_got[i], z_exp[i]);
        end

        // 1-byte frame padded to 60 + FCS = 64 handshakes
        rdy_mode = 0;
        frame_q.delete();
        frame_q.push_back(8'hAB);
        send_frame(1'b0, 0, 1'b0);
        wait_drain();
        chk("short_frame_len", last_frame_len, 64);

        // exactly MIN_P bytes: no pad, FCS follows immediately
        rand_frame(MIN_P);
        send_frame(1'b0, 0, 1'b0);
        wait_drain();
        chk("exact_frame_len", last_frame_len, MIN_P + 4);

        // downstream stall on FCS byte 2
        rdy_mode = 2;
        rand_frame(MIN_P);
        send_frame(1'b0, 0, 1'b0);
        wait_drain();
        chk("stall_seen", stall_done, 1'b1);

        // back-to-back frames with in_valid held high
        rdy_mode  = 0;
        gap_check = 1'b1;
        rand_frame(10);
        send_frame(1'b0, 0, 1'b1);
        rand_frame(MIN_P + 1);
        send_frame(1'b0, 0, 1'b0);
        wait_drain();
        chk("ifg_measured", gap_check, 1'b0);

        // reset mid-DATA at byte 20, then a clean frame
        rand_frame(40);
        send_frame(1'b0, 20, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rand_frame(30);
        send_frame(1'b0, 0, 1'b0);
        wait_drain();

        // randomized frames, gaps and backpressure
        rdy_mode = 1;
        for (int f = 0; f < 15; f++) begin
            rand_frame($urandom_range(1, 100));
            send_frame(1'b1, 0, 1'b0);
        end
        wait_drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
